out_port_tx: RTL
================

Name: out_port_tx

Overview:
- Transmit side of one router link (MGT direction); the counterpart of the input-queue/route-compute receive path.
- Buffers flits granted by the switch and sends them onto the link only while the downstream input queue has credits.
- Periodically inserts credit-return flits that tell the upstream router how many slots the local input queue has freed.
- One instance per direction (xpos shown in bring-up).

Parameters:
- FLIT_SIZE, 82, flit width; bit 81 = valid, bit 80 = is_credit.
- OUT_Q_LOG, 2, log2 of output FIFO depth (4 entries).
- CREDIT_W, 16, width of credit counters and of the credit payload field.
- CREDIT_INIT, 32, downstream input-queue slots (2^input_Q_size); reset value of the credit counter.
- credit_back_period, 100, maximum cycles between credit flits while credits are owed.
- credit_threshold, 8, owed-credit count that forces an immediate credit flit.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- flit_in  in  FLIT_SIZE  flit from switch.
- flit_in_valid  in  1  flit_in valid.
- flit_in_ready  out  1  FIFO not full.
- credit_rx_valid  in  1  a credit flit was decoded on the paired input link.
- credit_rx_count  in  CREDIT_W  credits returned by downstream.
- local_consume  in  1  pulse when the local input queue pops one flit (one credit owed upstream).
- out_flit  out  FLIT_SIZE  flit to MGT.
- out_valid  out  1  out_flit valid.
- credit_avail  out  CREDIT_W  current downstream credits.
- credit_err  out  1  sticky; credit overflow detected.

Behaviour:
- Reset (async assert, low): FIFO emptied, out_valid=0, out_flit=0, credit_avail=CREDIT_INIT, owed=0, timer=0, credit_err=0, FSM=IDLE.
- Input handshake: a flit is accepted when flit_in_valid && flit_in_ready. flit_in_ready = !full, combinational from registered FIFO state. A push while full cannot occur.
- FIFO: 2^OUT_Q_LOG entries. Push and pop in the same cycle are legal, including when full (push allowed only if ready was high).
- Output is registered: 1-cycle latency from the selection decision. out_flit=0 whenever out_valid=0.
- Arbitration each cycle, in priority order:
  - (a) Credit flit, if owed>0 and (timer==credit_back_period-1 or owed>=credit_threshold) and the previous output was not a credit flit.
  - (b) Data flit, if the FIFO is non-empty and credit_avail>0.
  - (c) Idle.
- FSM states: IDLE, DATA, CREDIT, one per output cycle. A CREDIT cycle is never followed directly by another CREDIT, so data cannot starve.
- Credit flit format: bit81=1, bit80=1, bits[CREDIT_W-1:0]=owed snapshot, all other bits 0.
- Data flit: FIFO head with bit81 forced to 1 and bit80 forced to 0.
- credit_avail:
  - next = credit_avail - (data sent) + (credit_rx_valid ? credit_rx_count : 0); a simultaneous send and receive nets out.
  - If next > CREDIT_INIT: clamp to CREDIT_INIT and set credit_err.
  - At 0, data is held in the FIFO and the FIFO fills; flit_in_ready drops when full.
- owed:
  - next = owed - (credit flit sent ? snapshot : 0) + local_consume.
  - A local_consume in the send cycle is kept for the next credit flit.
  - Saturates at 2^CREDIT_W-1.
- timer:
  - Increments while owed>0. Resets to 0 on a credit send or while owed==0.
  - Wraps at credit_back_period-1, which is the send trigger.
  - If the send is blocked by the no-back-to-back rule, timer holds at credit_back_period-1.
- Reset mid-operation: in-flight FIFO contents are dropped; no partial flit is ever emitted.

Decomposition:
- Shared package router_pkg: FLIT_SIZE, VALID_BIT=81, CREDIT_BIT=80, DIR_* codes, credit-flit field positions, FSM state enum.
- One sub-module: tx_fifo, a sync FIFO with count/full/empty. Do not reuse large_buffer, whose output behaviour is read-ahead.
- Credit and owed counters live in the top level.

Test Plan:
- Reset then push 3 data flits (payload 1,2,3), no local_consume -> out_valid on consecutive cycles starting 1 cycle after first accept; bit80=0; credit_avail goes 32→29.
- Send 32 flits with no credit_rx -> flit 33 held; FIFO fills to 4 and flit_in_ready=0. Then credit_rx_valid with count=5 -> 5 flits released, credit_avail back to 0.
- 3 local_consume pulses then idle -> exactly one credit flit with payload 3 when timer reaches 99; owed=0 afterwards.
- 8 local_consume pulses in consecutive cycles while the FIFO streams data -> a credit flit with payload 8 fires the cycle after owed hits 8. The next cycle is a data flit, not a credit flit.
- Data send and credit_rx_valid (count=1) in the same cycle at credit_avail=10 -> stays 10. credit_rx count=40 at credit_avail=30 -> clamps to 32, credit_err=1 sticky.
- Assert rst mid-stream with 2 flits in the FIFO -> out_valid=0 immediately (async), credit_avail=32, no stale flits after release.

Source files
------------

// File: rtl/out_port_tx_pkg.sv
// Shared router types and constants for the link transmit path.
// Holds the flit geometry, credit parameters, direction codes, the
// transmit FSM state enum and helpers that build outgoing flits.
package out_port_tx_pkg;

   localparam int unsigned FLIT_SIZE          = 82;
   localparam int unsigned VALID_BIT          = 81;
   localparam int unsigned CREDIT_BIT         = 80;
   localparam int unsigned OUT_Q_LOG          = 2;
   localparam int unsigned CREDIT_W           = 16;
   localparam int unsigned CREDIT_INIT        = 32;
   localparam int unsigned CREDIT_BACK_PERIOD = 100;
   localparam int unsigned CREDIT_THRESHOLD   = 8;
   localparam int unsigned TIMER_W            = $clog2(CREDIT_BACK_PERIOD);

   typedef enum logic [2:0] {
      DIR_XPOS, DIR_XNEG, DIR_YPOS, DIR_YNEG, DIR_ZPOS, DIR_ZNEG, DIR_LOCAL
   } dir_e;

   // One state per output cycle: what was driven onto the link last.
   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CREDIT} tx_state_e;

   typedef logic [FLIT_SIZE-1:0] flit_t;

   // Credit-return flit layout.
   typedef struct packed {
      logic                             valid;
      logic                             is_credit;
      logic [FLIT_SIZE-3-CREDIT_W:0]    rsvd;
      logic [CREDIT_W-1:0]              count;
   } credit_flit_t;

   function automatic flit_t make_credit_flit(input logic [CREDIT_W-1:0] count);
      credit_flit_t c;
      c           = '0;
      c.valid     = 1'b1;
      c.is_credit = 1'b1;
      c.count     = count;
      return c;
   endfunction

   // Data flits always leave marked valid and non-credit.
   function automatic flit_t make_data_flit(input flit_t head);
      flit_t f;
      f             = head;
      f[VALID_BIT]  = 1'b1;
      f[CREDIT_BIT] = 1'b0;
      return f;
   endfunction

endpackage

// File: rtl/out_port_tx_if.sv
// Switch-to-output-port flit handshake.
// flit_in/flit_in_valid driven by the switch, flit_in_ready by the port.
interface out_port_tx_if;
   import out_port_tx_pkg::*;

   logic [FLIT_SIZE-1:0] flit_in;
   logic                 flit_in_valid;
   logic                 flit_in_ready;

   modport master (output flit_in, output flit_in_valid, input flit_in_ready);
   modport slave  (input flit_in, input flit_in_valid, output flit_in_ready);
endinterface

// File: rtl/tx_fifo.sv
// Small synchronous FIFO buffering granted flits ahead of the link.
// Ports: push/push_data write, pop advances, head_c is the current head
// (valid when !empty_c), full_c/empty_c derived from the registered count.
module tx_fifo
   import out_port_tx_pkg::*;
#(
   parameter int unsigned WIDTH = FLIT_SIZE,
   parameter int unsigned LOG   = OUT_Q_LOG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_c,
   output logic             full_c,
   output logic             empty_c
);
   localparam int unsigned DEPTH = 1 << LOG;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LOG-1:0]   wr_ptr, rd_ptr;
   logic [LOG:0]     count;
   logic             do_push, do_pop;

   assign full_c  = (count == (LOG+1)'(DEPTH));
   assign empty_c = (count == '0);
   assign do_push = push && !full_c;
   assign do_pop  = pop && !empty_c;
   assign head_c  = mem[rd_ptr];

   // Pointer/count bookkeeping; push and pop may coincide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + LOG'(1);
         if (do_pop)  rd_ptr <= rd_ptr + LOG'(1);
         count <= count + (LOG+1)'(do_push) - (LOG+1)'(do_pop);
      end
   end

   // Storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/out_port_tx.sv
// Transmit side of one router link.
// Ports: clk, rst (async, active low); sw = switch flit handshake;
// credit_rx_valid/credit_rx_count = credits returned by downstream;
// local_consume = one local input-queue slot freed; out_flit/out_valid =
// registered flit to the MGT; credit_avail = downstream credits;
// credit_err = sticky credit-overflow flag.
module out_port_tx
   import out_port_tx_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   out_port_tx_if.slave         sw,
   input  logic                 credit_rx_valid,
   input  logic [CREDIT_W-1:0]  credit_rx_count,
   input  logic                 local_consume,
   output logic [FLIT_SIZE-1:0] out_flit,
   output logic                 out_valid,
   output logic [CREDIT_W-1:0]  credit_avail,
   output logic                 credit_err
);
   tx_state_e            state_q, state_d;
   logic [CREDIT_W-1:0]  owed_q, owed_d, credit_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [FLIT_SIZE-1:0] flit_d, head_c;
   logic [CREDIT_W:0]    credit_sum, owed_inc;
   logic                 fifo_full_c, fifo_empty_c, push, pop, credit_due, err_d;

   assign sw.flit_in_ready = !fifo_full_c;
   assign push             = sw.flit_in_valid && !fifo_full_c;

   tx_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (sw.flit_in),
      .pop       (pop),
      .head_c    (head_c),
      .full_c    (fifo_full_c),
      .empty_c   (fifo_empty_c)
   );

   // Output selection plus owed/timer/credit next-state.
   always_comb begin
      state_d    = ST_IDLE;
      flit_d     = '0;
      pop        = 1'b0;
      timer_d    = '0;
      err_d      = credit_err;
      owed_inc   = {1'b0, owed_q} + (CREDIT_W+1)'(local_consume);
      owed_d     = owed_inc[CREDIT_W] ? '1 : owed_inc[CREDIT_W-1:0];

      // Credit flits win, but never twice in a row so data keeps moving.
      credit_due = (owed_q != '0) && (state_q != ST_CREDIT) &&
                   ((timer_q == TIMER_W'(CREDIT_BACK_PERIOD - 1)) ||
                    (owed_q >= CREDIT_W'(CREDIT_THRESHOLD)));

      if (credit_due) begin
         state_d = ST_CREDIT;
         flit_d  = make_credit_flit(owed_q);
         owed_d  = CREDIT_W'(local_consume);
      end else if (!fifo_empty_c && (credit_avail != '0)) begin
         state_d = ST_DATA;
         pop     = 1'b1;
         flit_d  = make_data_flit(head_c);
      end

      // Timer parks at its trigger value while a credit send is blocked.
      if ((state_d != ST_CREDIT) && (owed_q != '0)) begin
         timer_d = (timer_q == TIMER_W'(CREDIT_BACK_PERIOD - 1)) ?
                   timer_q : timer_q + TIMER_W'(1);
      end

      credit_sum = {1'b0, credit_avail} - (CREDIT_W+1)'(pop) +
                   (credit_rx_valid ? {1'b0, credit_rx_count} : '0);
      if (credit_sum > (CREDIT_W+1)'(CREDIT_INIT)) begin
         credit_d = CREDIT_W'(CREDIT_INIT);
         err_d    = 1'b1;
      end else begin
         credit_d = credit_sum[CREDIT_W-1:0];
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         out_flit     <= '0;
         out_valid    <= 1'b0;
         credit_avail <= CREDIT_W'(CREDIT_INIT);
         credit_err   <= 1'b0;
         owed_q       <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         out_flit     <= flit_d;
         out_valid    <= (state_d != ST_IDLE);
         credit_avail <= credit_d;
         credit_err   <= err_d;
         owed_q       <= owed_d;
         timer_q      <= timer_d;
      end
   end

endmodule
